aha_tlx_output_lane: RTL and testbench
======================================

Name: aha_tlx_output_lane

Overview:
- Transmit side of one TLX training lane: serialises a programmed 32-bit training word onto a single data wire, LSB first, repeated for a programmed trip count or until cleared.
- Drives the lane wire that the matching TLX input lane samples and compares. The input lane reconstructs the word bit 0 first, so the bit order here is fixed.
- Sits in the TLX integration block beside the input lanes and is controlled from the same START/CLEAR/LENGTH/AUTO_STOP register fields.

Parameters:
- SEQ_W, 32, training word width; idx counter is clog2(SEQ_W) bits; only 32 is supported and verified.
- IDLE_LEVEL, 1'b0, value driven on D_OUT whenever a bit is not being transmitted.

Ports:
- CLK  input  1  clock.
- RESET  input  1  reset; asynchronous, active-high.
- START  input  1  level; its rising edge starts training.
- CLEAR  input  1  level; its rising edge aborts training and clears DONE and SENT_COUNT.
- SEQUENCE  input  32  training word; captured at start.
- LENGTH  input  32  number of whole words to send when AUTO_STOP=1; captured at start.
- AUTO_STOP  input  1  1 = stop after LENGTH words; 0 = run until CLEAR; captured at start.
- D_OUT  output  1  serial lane data, registered.
- DONE  output  1  sticky completion flag, registered.
- ACTIVE  output  1  training in progress.
- SENT_COUNT  output  32  number of complete words transmitted.

Behaviour:
- Reset values: D_OUT=IDLE_LEVEL, DONE=0, ACTIVE=0, SENT_COUNT=0, state=IDLE, idx=0. Reset mid-operation returns all state immediately; no partial word is completed.
- Edge detect: start_q and clear_q are registers, reset 0. start_pulse = START & ~start_q and clear_pulse = CLEAR & ~clear_q, both combinational. A held level gives exactly one pulse.
- FSM states are IDLE, TRAINING and FINISH. Clear has priority over start in every state.
- IDLE:
  - clear_pulse: stay in IDLE.
  - start_pulse: go to TRAINING. On the same edge capture seq_r<=SEQUENCE, len_r<=LENGTH, auto_r<=AUTO_STOP; set idx=0 and SENT_COUNT=0; clear DONE.
- TRAINING:
  - done_w = auto_r & (idx==0) & (SENT_COUNT==len_r).
  - clear_pulse: go to IDLE.
  - else if done_w: go to FINISH.
  - else stay. idx increments each cycle and wraps 31->0. SENT_COUNT increments on the cycle idx==31.
  - start_pulse is ignored while in TRAINING.
- FINISH: one cycle, then IDLE unconditionally. DONE is set on the FINISH edge.
- D_OUT: registered. D_OUT <= seq_r[idx] when state==TRAINING & ~done_w & ~clear_pulse; otherwise D_OUT <= IDLE_LEVEL. The first bit appears one cycle after the first TRAINING cycle.
- ACTIVE = (state==TRAINING) & ~done_w, combinational.
- DONE: set when done_w. Cleared by clear_pulse or start_pulse; clear has priority over set in the same cycle. Otherwise holds.
- SENT_COUNT: holds after FINISH or abort until the next start_pulse or clear_pulse, which zero it. Wraps modulo 2^32 when AUTO_STOP=0.
- LENGTH=0 with AUTO_STOP=1: done_w is true on the first TRAINING cycle, no bits are sent, DONE asserts, SENT_COUNT=0.
- Changing SEQUENCE, LENGTH or AUTO_STOP during TRAINING has no effect on the current run.
- CLEAR mid-word: the word is truncated, D_OUT returns to IDLE_LEVEL on the next edge, and SENT_COUNT=0.

Test Plan:
- Basic run: SEQUENCE=0xA5A50F0F, LENGTH=2, AUTO_STOP=1, START rises at cycle 0.
  - TRAINING cycles 1..64; D_OUT during cycles 2..65 = bits 0..31 of 0xA5A50F0F (1,1,1,1,0,0,0,0,...) twice.
  - ACTIVE high cycles 1..64; FINISH at cycle 66; DONE=1 from cycle 66; SENT_COUNT=2; D_OUT=0 afterwards.
- Loopback: connect D_OUT to the TLX input lane (same SEQUENCE, LENGTH=4, aligned start) -> input lane MATCH_COUNT>=4 and both DONE flags set.
- Free run: AUTO_STOP=0, SEQUENCE=0x00000001, LENGTH=0, then CLEAR at cycle 200.
  - D_OUT pulses high once every 32 cycles; DONE stays 0.
  - After CLEAR: IDLE, D_OUT=0, SENT_COUNT=0.
- Priority and ignore cases:
  - START and CLEAR rise on the same cycle in IDLE -> stays IDLE.
  - START re-pulsed mid-TRAINING -> ignored; idx and SENT_COUNT are unaffected.
- Corner case: LENGTH=0, AUTO_STOP=1 -> D_OUT never leaves 0, DONE=1 two cycles after the start pulse, SENT_COUNT=0. A later START clears DONE.
- Reset mid-word: RESET asserted at idx=17 in word 3 -> all outputs go to reset values asynchronously; a new START after release restarts from bit 0.

Source files
------------

// File: rtl/aha_tlx_output_lane.sv
// TLX training lane transmitter: serialises a captured 32-bit training word LSB first
// for a programmed number of words, or until cleared.
module aha_tlx_output_lane #(
    parameter int unsigned SEQ_W      = 32,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             CLEAR,
    input  logic [SEQ_W-1:0] SEQUENCE,
    input  logic [31:0]      LENGTH,
    input  logic             AUTO_STOP,
    output logic             D_OUT,
    output logic             DONE,
    output logic             ACTIVE,
    output logic [31:0]      SENT_COUNT
);

    localparam int unsigned     IDX_W    = $clog2(SEQ_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_W - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAINING = 2'd1,
        FINISH   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               start_q, clear_q;
    logic               start_pulse, clear_pulse;
    logic               done_w;
    logic               load;
    logic [SEQ_W-1:0]   seq_r;
    logic [31:0]        len_r;
    logic               auto_r;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [31:0]        sent_nxt;
    logic               done_nxt;
    logic               dout_nxt;

    assign start_pulse = START & ~start_q;
    assign clear_pulse = CLEAR & ~clear_q;

    // Completion is only meaningful at a word boundary while training.
    assign done_w = (state == TRAINING) & auto_r & (idx == '0) & (SENT_COUNT == len_r);
    assign ACTIVE = (state == TRAINING) & ~done_w;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        sent_nxt  = SENT_COUNT;
        done_nxt  = DONE;
        dout_nxt  = IDLE_LEVEL;
        load      = 1'b0;

        case (state)
            IDLE: begin
                if (!clear_pulse && start_pulse) begin
                    state_nxt = TRAINING;
                    load      = 1'b1;
                    idx_nxt   = '0;
                    sent_nxt  = '0;
                    done_nxt  = 1'b0;
                end
            end
            TRAINING: begin
                if (clear_pulse) begin
                    state_nxt = IDLE;
                end else if (done_w) begin
                    state_nxt = FINISH;
                end else begin
                    dout_nxt = seq_r[idx];
                    idx_nxt  = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        sent_nxt = SENT_COUNT + 32'd1;
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (done_w) begin
            done_nxt = 1'b1;
        end
        // Clear wins over everything, including a same-cycle completion.
        if (clear_pulse) begin
            done_nxt = 1'b0;
            sent_nxt = '0;
            idx_nxt  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            idx        <= '0;
            SENT_COUNT <= '0;
            DONE       <= 1'b0;
            D_OUT      <= IDLE_LEVEL;
            seq_r      <= '0;
            len_r      <= '0;
            auto_r     <= 1'b0;
        end else begin
            state      <= state_nxt;
            start_q    <= START;
            clear_q    <= CLEAR;
            idx        <= idx_nxt;
            SENT_COUNT <= sent_nxt;
            DONE       <= done_nxt;
            D_OUT      <= dout_nxt;
            if (load) begin
                seq_r  <= SEQUENCE;
                len_r  <= LENGTH;
                auto_r <= AUTO_STOP;
            end
        end
    end

endmodule

// File: tb/tb_aha_tlx_output_lane.sv
// Scoreboard bench for aha_tlx_output_lane: stimulus queues the expected serial bit
// stream per run, a negedge monitor pops and compares every transmitted bit.
module tb_aha_tlx_output_lane;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic        CLEAR = 1'b0;
    logic        AUTO_STOP = 1'b0;
    logic [31:0] SEQUENCE = '0;
    logic [31:0] LENGTH = '0;
    logic        D_OUT, DONE, ACTIVE;
    logic [31:0] SENT_COUNT;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];

    always #5 CLK = ~CLK;

    aha_tlx_output_lane dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .CLEAR      (CLEAR),
        .SEQUENCE   (SEQUENCE),
        .LENGTH     (LENGTH),
        .AUTO_STOP  (AUTO_STOP),
        .D_OUT      (D_OUT),
        .DONE       (DONE),
        .ACTIVE     (ACTIVE),
        .SENT_COUNT (SENT_COUNT)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: a bit is on the wire in the cycle after an ACTIVE cycle that was not aborted.
    bit snd_prev = 1'b0;
    bit clr_prev = 1'b0;
    always @(negedge CLK) begin
        bit e;
        if (RESET) begin
            snd_prev = 1'b0;
            clr_prev = 1'b0;
        end else begin
            if (snd_prev) begin
                if (exp_q.size() == 0) begin
                    chk("extra_bit", 32'(D_OUT), 32'(1'bx));
                end else begin
                    e = exp_q.pop_front();
                    chk("d_out_bit", 32'(D_OUT), 32'(e));
                end
            end else begin
                chk("d_out_idle", 32'(D_OUT), 32'd0);
            end
            snd_prev = ACTIVE && !(CLEAR && !clr_prev);
            clr_prev = CLEAR;
        end
    end

    task automatic push_bits(input logic [31:0] seq, input int nbits);
        for (int k = 0; k < nbits; k++) exp_q.push_back(seq[k % 32]);
    endtask

    task automatic scramble_inputs();
        SEQUENCE  = $urandom;
        LENGTH    = $urandom;
        AUTO_STOP = 1'($urandom_range(0, 1));
    endtask

    task automatic run_auto(input logic [31:0] seq, input int len, input bit repulse);
        int cyc;
        tick();
        SEQUENCE = seq; LENGTH = 32'(len); AUTO_STOP = 1'b1; START = 1'b1;
        push_bits(seq, 32 * len);
        tick();
        chk("start_clears_done", 32'(DONE), 32'd0);
        chk("start_zeroes_sent", SENT_COUNT, 32'd0);
        chk("active_first_cycle", 32'(ACTIVE), 32'(len != 0));
        START = 1'b0;
        scramble_inputs();
        cyc = 1;
        while (DONE !== 1'b1 && cyc < 32 * len + 20) begin
            tick();
            cyc++;
            if (repulse && cyc == 40) START = 1'b1;
            if (repulse && cyc == 42) START = 1'b0;
        end
        chk("done_latency", 32'(cyc), 32'(2 + 32 * len));
        chk("done_set", 32'(DONE), 32'd1);
        chk("sent_final", SENT_COUNT, 32'(len));
        chk("active_after", 32'(ACTIVE), 32'd0);
        chk("bits_consumed", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_free(input logic [31:0] seq, input int w);
        tick();
        SEQUENCE = seq; LENGTH = '0; AUTO_STOP = 1'b0; START = 1'b1;
        push_bits(seq, w);
        tick();
        chk("free_start_clears_done", 32'(DONE), 32'd0);
        START = 1'b0;
        scramble_inputs();
        repeat (w) tick();
        chk("free_sent", SENT_COUNT, 32'(w / 32));
        chk("free_done_low", 32'(DONE), 32'd0);
        chk("free_active", 32'(ACTIVE), 32'd1);
        CLEAR = 1'b1;
        tick();
        chk("clr_active", 32'(ACTIVE), 32'd0);
        chk("clr_sent", SENT_COUNT, 32'd0);
        chk("clr_done", 32'(DONE), 32'd0);
        chk("free_bits_consumed", 32'(exp_q.size()), 32'd0);
        CLEAR = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        #1 RESET = 1'b1;
        #1;
        chk("rst_d_out", 32'(D_OUT), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_active", 32'(ACTIVE), 32'd0);
        chk("rst_sent", SENT_COUNT, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        repeat (3) tick();

        run_auto(32'hA5A50F0F, 2, 1'b0);

        // START and CLEAR together in IDLE: stays idle, sticky DONE is cleared
        tick();
        START = 1'b1; CLEAR = 1'b1; SEQUENCE = $urandom; LENGTH = 32'd1; AUTO_STOP = 1'b1;
        tick();
        chk("both_active", 32'(ACTIVE), 32'd0);
        chk("both_done", 32'(DONE), 32'd0);
        chk("both_sent", SENT_COUNT, 32'd0);
        START = 1'b0; CLEAR = 1'b0;
        repeat (5) tick();
        chk("both_still_idle", 32'(ACTIVE), 32'd0);

        run_auto($urandom, 0, 1'b0);
        run_auto($urandom, 1, 1'b0);
        run_auto($urandom, 3, 1'b1);
        run_free(32'h00000001, 199);

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) run_auto($urandom, int'($urandom_range(0, 3)), 1'b0);
            else run_free($urandom, int'($urandom_range(1, 100)));
        end

        // Reset in the middle of word 3, bit 17
        s = $urandom;
        tick();
        SEQUENCE = s; LENGTH = 32'd5; AUTO_STOP = 1'b1; START = 1'b1;
        push_bits(s, 160);
        tick();
        START = 1'b0;
        repeat (81) tick();
        chk("pre_reset_sent", SENT_COUNT, 32'd2);
        chk("pre_reset_active", 32'(ACTIVE), 32'd1);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_d_out", 32'(D_OUT), 32'd0);
        chk("mid_rst_done", 32'(DONE), 32'd0);
        chk("mid_rst_active", 32'(ACTIVE), 32'd0);
        chk("mid_rst_sent", SENT_COUNT, 32'd0);
        chk("mid_rst_bits_sent", 32'(exp_q.size()), 32'd80);
        exp_q.delete();
        tick();
        tick();
        RESET = 1'b0;
        repeat (3) tick();
        run_auto($urandom, 2, 1'b0);

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
